// File: rtl/ahb_apb_bridge_nslv_pkg.sv
// Shared definitions for the single-clock AHB-Lite to APB bridge.
//   - HTRANS / HRESP encodings
//   - bridge FSM state type
//   - width helper for index and counter fields
package ahb_apb_bridge_nslv_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    // clog2 that never returns 0, so single-entry fields stay 1 bit wide
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_nslv_apb_mux.sv
// APB slave select decode and response mux.
// Ports:
//   i_dec_idx   slave index to decode into a one-hot select
//   i_rsp_idx   slave index whose response is returned
//   i_prdata    packed read data, slave k at [k*DATA_W +: DATA_W]
//   i_pready    per-slave ready
//   i_pslverr   per-slave error
//   o_psel_dec  one-hot decode of i_dec_idx (all zero if out of range)
//   o_prdata    read data of slave i_rsp_idx
//   o_pready    ready of slave i_rsp_idx
//   o_pslverr   error of slave i_rsp_idx
module ahb_apb_bridge_nslv_apb_mux #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned SW      = 2
) (
    input  logic [SW-1:0]             i_dec_idx,
    input  logic [SW-1:0]             i_rsp_idx,
    input  logic [NUM_SLV*DATA_W-1:0] i_prdata,
    input  logic [NUM_SLV-1:0]        i_pready,
    input  logic [NUM_SLV-1:0]        i_pslverr,
    output logic [NUM_SLV-1:0]        o_psel_dec,
    output logic [DATA_W-1:0]         o_prdata,
    output logic                      o_pready,
    output logic                      o_pslverr
);

    always_comb begin
        o_psel_dec = '0;
        o_prdata   = '0;
        o_pready   = 1'b0;
        o_pslverr  = 1'b0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (i_dec_idx == SW'(k)) begin
                o_psel_dec[k] = 1'b1;
            end
            if (i_rsp_idx == SW'(k)) begin
                o_prdata  = i_prdata[k*DATA_W +: DATA_W];
                o_pready  = i_pready[k];
                o_pslverr = i_pslverr[k];
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_nslv.sv
// Single-clock AHB-Lite slave to APB master bridge with NUM_SLV decoded APB slaves.
// Ports:
//   i_hclk        clock for both bus sides
//   i_hreset      asynchronous active-high reset
//   i_hsel        bridge selected
//   i_htrans      AHB transfer type
//   i_haddr       AHB address
//   i_hwrite      1 = write
//   i_hwdata      AHB write data (data phase)
//   i_hready_in   bus HREADY
//   o_hready_out  this slave's HREADY
//   o_hresp       0 = OKAY, 1 = ERROR
//   o_hrdata      read data (selected slave's PRDATA in ACCESS, else 0)
//   o_paddr       APB address
//   o_psel        one-hot APB select
//   o_penable     APB enable
//   o_pwrite      APB direction
//   o_pwdata      APB write data
//   i_prdata      slave k read data at [k*DATA_W +: DATA_W]
//   i_pready      per-slave ready
//   i_pslverr     per-slave error
module ahb_apb_bridge_nslv
    import ahb_apb_bridge_nslv_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_SLV     = 4,
    parameter int unsigned SLV_SEL_LSB = 12,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                      i_hclk,
    input  logic                      i_hreset,
    input  logic                      i_hsel,
    input  logic [1:0]                i_htrans,
    input  logic [ADDR_W-1:0]         i_haddr,
    input  logic                      i_hwrite,
    input  logic [DATA_W-1:0]         i_hwdata,
    input  logic                      i_hready_in,
    output logic                      o_hready_out,
    output logic                      o_hresp,
    output logic [DATA_W-1:0]         o_hrdata,
    output logic [ADDR_W-1:0]         o_paddr,
    output logic [NUM_SLV-1:0]        o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [DATA_W-1:0]         o_pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] i_prdata,
    input  logic [NUM_SLV-1:0]        i_pready,
    input  logic [NUM_SLV-1:0]        i_pslverr
);

    localparam int unsigned SW = clog2_min1(NUM_SLV);
    localparam int unsigned TW = clog2_min1(TIMEOUT + 1);

    state_e              r_state;
    logic [SW-1:0]       r_idx;
    logic [TW-1:0]       r_tcnt;
    logic [ADDR_W-1:0]   r_paddr;
    logic [NUM_SLV-1:0]  r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;

    logic [SW-1:0]       w_haddr_idx;
    logic                w_idx_bad;
    logic                w_accept;
    logic [SW-1:0]       w_dec_idx;
    logic [NUM_SLV-1:0]  w_psel_dec;
    logic [DATA_W-1:0]   w_prdata_sel;
    logic                w_pready_sel;
    logic                w_pslverr_sel;
    logic                w_timeout;
    logic                w_ok_done;
    state_e              w_launch_state;
    logic [NUM_SLV-1:0]  w_launch_psel;

    assign w_haddr_idx = i_haddr[SLV_SEL_LSB +: SW];
    assign w_idx_bad   = (32'(w_haddr_idx) >= NUM_SLV);
    assign w_accept    = i_hsel && i_hready_in &&
                         ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));

    // Reads go straight to SETUP, so decode the incoming address; writes decode the latched index
    // when leaving WDATA.
    assign w_dec_idx = (r_state == StWdata) ? r_idx : w_haddr_idx;

    ahb_apb_bridge_nslv_apb_mux #(
        .DATA_W  (DATA_W),
        .NUM_SLV (NUM_SLV),
        .SW      (SW)
    ) u_apb_mux (
        .i_dec_idx  (w_dec_idx),
        .i_rsp_idx  (r_idx),
        .i_prdata   (i_prdata),
        .i_pready   (i_pready),
        .i_pslverr  (i_pslverr),
        .o_psel_dec (w_psel_dec),
        .o_prdata   (w_prdata_sel),
        .o_pready   (w_pready_sel),
        .o_pslverr  (w_pslverr_sel)
    );

    assign w_timeout = (TIMEOUT != 0) && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_ok_done = w_pready_sel && !w_pslverr_sel;

    // Where an accepted transfer goes, and the select it drives on that edge
    assign w_launch_state = w_idx_bad ? StErr1 : (i_hwrite ? StWdata : StSetup);
    assign w_launch_psel  = (!w_idx_bad && !i_hwrite) ? w_psel_dec : '0;

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_tcnt    <= '0;
            r_paddr   <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
        end else begin
            unique case (r_state)
                StIdle, StErr2: begin
                    if (w_accept) begin
                        r_state <= w_launch_state;
                        r_psel  <= w_launch_psel;
                        r_paddr <= i_haddr;
                        r_pwrite <= i_hwrite;
                        r_idx   <= w_haddr_idx;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StWdata: begin
                    r_pwdata <= i_hwdata;
                    r_psel   <= w_psel_dec;
                    r_state  <= StSetup;
                end
                StSetup: begin
                    r_penable <= 1'b1;
                    r_tcnt    <= '0;
                    r_state   <= StAccess;
                end
                StAccess: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_pready_sel) begin
                        r_penable <= 1'b0;
                        r_psel    <= '0;
                        if (w_pslverr_sel) begin
                            r_state <= StErr1;
                        end else if (w_accept) begin
                            r_state  <= w_launch_state;
                            r_psel   <= w_launch_psel;
                            r_paddr  <= i_haddr;
                            r_pwrite <= i_hwrite;
                            r_idx    <= w_haddr_idx;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else if (w_timeout) begin
                        // Abandon the access; the slave never answered
                        r_penable <= 1'b0;
                        r_psel    <= '0;
                        r_state   <= StErr1;
                    end
                end
                StErr1: begin
                    r_state <= StErr2;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        o_hready_out = 1'b1;
        o_hresp      = HRESP_OKAY;
        o_hrdata     = '0;
        unique case (r_state)
            StIdle: ;
            StWdata, StSetup: o_hready_out = 1'b0;
            StAccess: begin
                o_hready_out = w_ok_done;
                o_hrdata     = w_prdata_sel;
            end
            StErr1: begin
                o_hready_out = 1'b0;
                o_hresp      = HRESP_ERROR;
            end
            StErr2: o_hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    assign o_paddr   = r_paddr;
    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_pwdata  = r_pwdata;

endmodule

// File: tb/tb_ahb_apb_bridge_nslv.sv
// Scoreboard bench for ahb_apb_bridge_nslv (NUM_SLV=3, TIMEOUT=4).
// Stimulus pushes expected AHB completions and APB accesses into queues; two monitors pop and
// compare whenever the DUT completes an AHB data phase or starts an APB SETUP.
module tb_ahb_apb_bridge_nslv;

    localparam int unsigned NSLV = 3;

    typedef struct {
        string       name;
        logic        err;
        logic        rd;
        logic [31:0] rdata;
        int          waits;
    } ahb_exp_t;

    typedef struct {
        string       name;
        logic [2:0]  psel;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        int          acc;
    } apb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             hsel = 1'b0;
    logic [1:0]       htrans = 2'b00;
    logic [31:0]      haddr = '0;
    logic             hwrite = 1'b0;
    logic [31:0]      hwdata = '0;
    logic             hready_en = 1'b1;
    logic             hready_in;
    logic             hready_out;
    logic             hresp;
    logic [31:0]      hrdata;
    logic [31:0]      paddr;
    logic [NSLV-1:0]  psel;
    logic             penable;
    logic             pwrite;
    logic [31:0]      pwdata;
    logic [NSLV*32-1:0] prdata;
    logic [NSLV-1:0]  pready;
    logic [NSLV-1:0]  pslverr;

    int n_vec = 0;
    int n_err = 0;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];
    xfer_t    seq[$];

    // APB slave model: selected slave waits wait_n ACCESS cycles; others always answer ready+error
    int   wait_n = 0;
    logic err_en = 1'b0;
    int   acc_cnt = 0;
    logic sel_rdy;

    always #5 clk = ~clk;

    assign hready_in = hready_out & hready_en;
    assign sel_rdy   = (acc_cnt >= wait_n);

    always_comb begin
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        for (int k = 0; k < NSLV; k++) begin
            prdata[k*32 +: 32] = 32'hCAFE0000 + 32'(k);
            pready[k]  = psel[k] ? sel_rdy : 1'b1;
            pslverr[k] = psel[k] ? (err_en && sel_rdy) : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (penable && (psel != '0) && !sel_rdy) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    ahb_apb_bridge_nslv #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .NUM_SLV     (NSLV),
        .SLV_SEL_LSB (12),
        .TIMEOUT     (4)
    ) dut (
        .i_hclk       (clk),
        .i_hreset     (rst),
        .i_hsel       (hsel),
        .i_htrans     (htrans),
        .i_haddr      (haddr),
        .i_hwrite     (hwrite),
        .i_hwdata     (hwdata),
        .i_hready_in  (hready_in),
        .o_hready_out (hready_out),
        .o_hresp      (hresp),
        .o_hrdata     (hrdata),
        .o_paddr      (paddr),
        .o_psel       (psel),
        .o_penable    (penable),
        .o_pwrite     (pwrite),
        .o_pwdata     (pwdata),
        .i_prdata     (prdata),
        .i_pready     (pready),
        .i_pslverr    (pslverr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // ---------------- AHB monitor ----------------
    logic     dphase;
    int       waits = 0;
    logic     prev_hresp = 1'b0;
    ahb_exp_t ae;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dphase <= 1'b0;
        else if (hready_in) dphase <= hsel && htrans[1];
    end

    always @(negedge clk) begin
        if (rst) begin
            waits = 0;
        end else if (dphase) begin
            if (!hready_out) begin
                waits++;
                prev_hresp = hresp;
            end else begin
                if (ahb_q.size() == 0) begin
                    flag("ahb_unexpected_completion");
                end else begin
                    ae = ahb_q.pop_front();
                    check({ae.name, "_hresp"}, 64'(hresp), 64'(ae.err));
                    check({ae.name, "_waits"}, 64'(waits), 64'(ae.waits));
                    if (ae.err) check({ae.name, "_hresp_1st"}, 64'(prev_hresp), 64'(1));
                    if (ae.rd && !ae.err) check({ae.name, "_hrdata"}, 64'(hrdata), 64'(ae.rdata));
                end
                waits = 0;
            end
        end
    end

    // ---------------- APB monitor ----------------
    logic     apb_active = 1'b0;
    int       acc = 0;
    apb_exp_t pe;

    always @(negedge clk) begin
        if (rst) begin
            apb_active = 1'b0;
        end else begin
            if (!$onehot0(psel)) flag("apb_psel_not_onehot");
            if (psel != '0 && !penable) begin
                if (apb_active) check({pe.name, "_acc_cycles"}, 64'(acc), 64'(pe.acc));
                if (apb_q.size() == 0) begin
                    flag("apb_unexpected_setup");
                    apb_active = 1'b0;
                end else begin
                    pe = apb_q.pop_front();
                    check({pe.name, "_psel"}, 64'(psel), 64'(pe.psel));
                    check({pe.name, "_paddr"}, 64'(paddr), 64'(pe.paddr));
                    check({pe.name, "_pwrite"}, 64'(pwrite), 64'(pe.pwrite));
                    if (pe.pwrite) check({pe.name, "_pwdata"}, 64'(pwdata), 64'(pe.pwdata));
                    apb_active = 1'b1;
                    acc = 0;
                end
            end else if (psel != '0) begin
                if (!apb_active) begin
                    flag("apb_access_without_setup");
                end else begin
                    acc++;
                    check({pe.name, "_acc_psel"}, 64'(psel), 64'(pe.psel));
                    check({pe.name, "_acc_paddr"}, 64'(paddr), 64'(pe.paddr));
                    if (pe.pwrite) check({pe.name, "_acc_pwdata"}, 64'(pwdata), 64'(pe.pwdata));
                end
            end else begin
                if (penable) flag("apb_penable_without_psel");
                if (apb_active) check({pe.name, "_acc_cycles"}, 64'(acc), 64'(pe.acc));
                apb_active = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic exp_ahb(input string name, input logic err, input logic rd,
                           input logic [31:0] rdata, input int w);
        ahb_exp_t e;
        e.name = name; e.err = err; e.rd = rd; e.rdata = rdata; e.waits = w;
        ahb_q.push_back(e);
    endtask

    task automatic exp_apb(input string name, input logic [2:0] s, input logic [31:0] a,
                           input logic w, input logic [31:0] d, input int n);
        apb_exp_t e;
        e.name = name; e.psel = s; e.paddr = a; e.pwrite = w; e.pwdata = d; e.acc = n;
        apb_q.push_back(e);
    endtask

    task automatic add_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.wr = w; x.wdata = d;
        seq.push_back(x);
    endtask

    // Waits for a clock edge with HREADY high; leaves time at posedge+1
    task automatic wait_hready(input string name);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = hready_in;
            @(posedge clk);
            #1;
        end
        if (!ok) flag({name, "_hready_timeout"});
    endtask

    // Issues all queued transfers back to back, NONSEQ each, with write data one phase behind
    task automatic run_seq(input string name);
        int n;
        n = seq.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                hsel = 1'b1; htrans = 2'b10; haddr = seq[i].addr; hwrite = seq[i].wr;
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            if (i > 0) hwdata = seq[i-1].wdata;
            wait_hready(name);
        end
        seq.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hready_out", 64'(hready_out), 64'(1));
        check("rst_hresp", 64'(hresp), 64'(0));
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_pwrite", 64'(pwrite), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_pwdata", 64'(pwdata), 64'(0));
        check("rst_hrdata", 64'(hrdata), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: zero-wait read of slave 1
        wait_n = 0; err_en = 1'b0;
        exp_apb("t1", 3'b010, 32'h1004, 1'b0, 32'h0, 1);
        exp_ahb("t1", 1'b0, 1'b1, 32'hCAFE0001, 1);
        add_xfer(32'h1004, 1'b0, 32'h0);
        run_seq("t1");

        // 2: write with PREADY low 3 cycles (one short of the timeout)
        wait_n = 3;
        exp_apb("t2", 3'b100, 32'h2008, 1'b1, 32'hA5A5A5A5, 4);
        exp_ahb("t2", 1'b0, 1'b0, 32'h0, 5);
        add_xfer(32'h2008, 1'b1, 32'hA5A5A5A5);
        run_seq("t2");

        // 3: PSLVERR at PREADY -> two-cycle ERROR
        wait_n = 0; err_en = 1'b1;
        exp_apb("t3", 3'b001, 32'h0010, 1'b0, 32'h0, 1);
        exp_ahb("t3", 1'b1, 1'b1, 32'h0, 3);
        add_xfer(32'h0010, 1'b0, 32'h0);
        run_seq("t3");
        err_en = 1'b0;

        // 4: PREADY stuck -> timeout after 4 ACCESS cycles, then a clean transfer
        wait_n = 1000;
        exp_apb("t4", 3'b010, 32'h1020, 1'b0, 32'h0, 4);
        exp_ahb("t4", 1'b1, 1'b1, 32'h0, 6);
        add_xfer(32'h1020, 1'b0, 32'h0);
        run_seq("t4");
        wait_n = 0;
        exp_apb("t4_next", 3'b001, 32'h0000, 1'b0, 32'h0, 1);
        exp_ahb("t4_next", 1'b0, 1'b1, 32'hCAFE0000, 1);
        add_xfer(32'h0000, 1'b0, 32'h0);
        run_seq("t4_next");

        // 5: index 3 is out of range with 3 slaves
        exp_ahb("t5", 1'b1, 1'b1, 32'h0, 1);
        add_xfer(32'h3000, 1'b0, 32'h0);
        run_seq("t5");

        // 6: back-to-back write->read and read->write
        exp_apb("t6_wr", 3'b100, 32'h2010, 1'b1, 32'h12345678, 1);
        exp_apb("t6_rd", 3'b010, 32'h1008, 1'b0, 32'h0, 1);
        exp_ahb("t6_wr", 1'b0, 1'b0, 32'h0, 2);
        exp_ahb("t6_rd", 1'b0, 1'b1, 32'hCAFE0001, 1);
        add_xfer(32'h2010, 1'b1, 32'h12345678);
        add_xfer(32'h1008, 1'b0, 32'h0);
        run_seq("t6a");
        exp_apb("t6_rd2", 3'b001, 32'h0004, 1'b0, 32'h0, 1);
        exp_apb("t6_wr2", 3'b010, 32'h1000, 1'b1, 32'h0BADF00D, 1);
        exp_ahb("t6_rd2", 1'b0, 1'b1, 32'hCAFE0000, 1);
        exp_ahb("t6_wr2", 1'b0, 1'b0, 32'h0, 2);
        add_xfer(32'h0004, 1'b0, 32'h0);
        add_xfer(32'h1000, 1'b1, 32'h0BADF00D);
        run_seq("t6b");

        // HREADY_IN low in IDLE: request ignored
        hready_en = 1'b0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h1000; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hready_en = 1'b1;
        @(negedge clk);
        check("idle_nordy_psel", 64'(psel), 64'(0));
        check("idle_nordy_hready", 64'(hready_out), 64'(1));

        // BUSY transfer: zero-wait OKAY, no APB access
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b01; haddr = 32'h1000;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("busy_hready", 64'(hready_out), 64'(1));
        check("busy_hresp", 64'(hresp), 64'(0));
        check("busy_psel", 64'(psel), 64'(0));

        // Async reset in ACCESS drops PSEL immediately
        @(posedge clk); #1;
        wait_n = 1000;
        exp_apb("t6_rst", 3'b010, 32'h100C, 1'b0, 32'h0, 0);
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h100C; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        @(posedge clk); #1;
        check("pre_rst_penable", 64'(penable), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_psel", 64'(psel), 64'(0));
        check("rst_async_penable", 64'(penable), 64'(0));
        check("rst_async_hready", 64'(hready_out), 64'(1));
        check("rst_async_hresp", 64'(hresp), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        wait_n = 0;
        @(posedge clk); #1;
        exp_apb("post_rst", 3'b010, 32'h1000, 1'b0, 32'h0, 1);
        exp_ahb("post_rst", 1'b0, 1'b1, 32'hCAFE0001, 1);
        add_xfer(32'h1000, 1'b0, 32'h0);
        run_seq("post_rst");

        repeat (3) @(posedge clk);
        check("ahb_q_drained", 64'(ahb_q.size()), 64'(0));
        check("apb_q_drained", 64'(apb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

endmodule
